// File: rtl/pc_unit.sv
// Fetch-stage program counter: priority next-PC select (trap, redirect, RAS return,
// sequential) with stall hold, misaligned-redirect flagging and a circular return-address stack.
module pc_unit #(
   parameter int                XLEN         = 32,
   parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000,
   parameter int                RAS_DEPTH    = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_vector,
   input  logic            call_push,
   input  logic            ret_pop,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            misaligned,
   output logic            ras_empty,
   output logic            ras_full
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(RAS_DEPTH + 1);
   localparam logic [PW-1:0] ONE_P   = PW'(1);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

   logic [XLEN-1:0] pc_q, pc_next;
   logic            mis_q, mis_next;
   logic [PW-1:0]   top_q, top_next;
   logic [CW-1:0]   count_q, count_next;
   logic            ras_we;
   logic [PW-1:0]   ras_waddr;
   logic [XLEN-1:0] ras [RAS_DEPTH];

   assign pc         = pc_q;
   assign pc_plus4   = pc_q + XLEN'(4);
   assign misaligned = mis_q;
   assign ras_empty  = (count_q == '0);
   assign ras_full   = (count_q == DEPTH_C);

   // Redirect and trap are single-cycle strobes; nothing is queued or acknowledged.
   always_comb begin
      pc_next    = pc_q;
      mis_next   = 1'b0;
      top_next   = top_q;
      count_next = count_q;
      ras_we     = 1'b0;
      ras_waddr  = top_q;
      if (trap_valid) begin
         pc_next    = trap_vector & ~XLEN'(3);
         count_next = '0;
      end else if (redirect_valid && redirect_target[1:0] == 2'b00) begin
         pc_next = redirect_target;
      end else if (redirect_valid) begin
         mis_next = 1'b1;
      end else if (!stall) begin
         if (ret_pop && !ras_empty) begin
            pc_next = ras[top_q];
            if (call_push) begin
               // Pop-then-push collapses to replacing the top entry in place.
               ras_we = 1'b1;
            end else begin
               top_next   = top_q - ONE_P;
               count_next = count_q - ONE_C;
            end
         end else begin
            pc_next = pc_plus4;
            if (call_push) begin
               ras_we    = 1'b1;
               ras_waddr = top_q + ONE_P;
               top_next  = top_q + ONE_P;
               if (!ras_full) count_next = count_q + ONE_C;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_VECTOR;
         mis_q   <= 1'b0;
         top_q   <= '0;
         count_q <= '0;
      end else begin
         pc_q    <= pc_next;
         mis_q   <= mis_next;
         top_q   <= top_next;
         count_q <= count_next;
      end
   end

   // Entry storage is not reset; only the count decides what is valid.
   always_ff @(posedge clk) begin
      if (ras_we) ras[ras_waddr] <= pc_plus4;
   end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table, random stimulus against a queue-based
// model, and an asynchronous mid-cycle reset sequence.
module tb_pc_unit;

   localparam int          XLEN  = 32;
   localparam logic [31:0] RV    = 32'h0000_0000;
   localparam int          DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, redirect_valid, trap_valid, call_push, ret_pop;
   logic [31:0] redirect_target, trap_vector;
   logic [31:0] pc, pc_plus4;
   logic        misaligned, ras_empty, ras_full;

   int total = 0;
   int bad   = 0;

   pc_unit #(.XLEN(XLEN), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .trap_valid(trap_valid), .trap_vector(trap_vector),
      .call_push(call_push), .ret_pop(ret_pop),
      .pc(pc), .pc_plus4(pc_plus4), .misaligned(misaligned),
      .ras_empty(ras_empty), .ras_full(ras_full)
   );

   always #5 clk = ~clk;

   // Reference model: the return stack is a plain queue, newest entry at the back.
   logic [31:0] m_pc;
   logic        m_mis;
   logic [31:0] m_ras[$];

   task automatic model_reset();
      m_pc  = RV;
      m_mis = 1'b0;
      m_ras.delete();
   endtask

   task automatic model_step(input logic st, input logic rd, input logic [31:0] tg,
                             input logic tr, input logic [31:0] tv,
                             input logic ps, input logic pp);
      logic [31:0] seq;
      seq   = m_pc + 32'd4;
      m_mis = 1'b0;
      if (tr) begin
         m_pc = {tv[31:2], 2'b00};
         m_ras.delete();
      end else if (rd && tg[1:0] == 2'b00) begin
         m_pc = tg;
      end else if (rd) begin
         m_mis = 1'b1;
      end else if (st) begin
         m_pc = m_pc;
      end else if (pp && m_ras.size() > 0) begin
         m_pc = m_ras.pop_back();
         if (ps) m_ras.push_back(seq);
      end else begin
         m_pc = seq;
         if (ps) begin
            m_ras.push_back(seq);
            if (m_ras.size() > DEPTH) m_ras.delete(0);
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      chk("model_pc", pc, m_pc);
      chk("model_pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("model_mis", {31'd0, misaligned}, {31'd0, m_mis});
      chk("model_empty", {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
      chk("model_full", {31'd0, ras_full}, {31'd0, m_ras.size() == DEPTH});
   endtask

   // Drive one cycle of inputs, clock it, then compare against the model.
   task automatic step(input logic st, input logic rd, input logic [31:0] tg,
                       input logic tr, input logic [31:0] tv,
                       input logic ps, input logic pp);
      stall = st; redirect_valid = rd; redirect_target = tg;
      trap_valid = tr; trap_vector = tv; call_push = ps; ret_pop = pp;
      @(posedge clk);
      #1;
      model_step(st, rd, tg, tr, tv, ps, pp);
      chk_model();
   endtask

   typedef struct {
      logic        st, rd, tr, ps, pp;
      logic [31:0] tg, tv;
      logic [31:0] exp_pc;
      logic        exp_mis, exp_empty, exp_full;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(logic st, logic rd, logic [31:0] tg, logic tr, logic [31:0] tv,
                               logic ps, logic pp, logic [31:0] epc,
                               logic emis, logic eemp, logic efull);
      vec_t v;
      v.st = st; v.rd = rd; v.tg = tg; v.tr = tr; v.tv = tv; v.ps = ps; v.pp = pp;
      v.exp_pc = epc; v.exp_mis = emis; v.exp_empty = eemp; v.exp_full = efull;
      vecs.push_back(v);
   endfunction

   initial begin
      rst_n = 1'b0;
      stall = 0; redirect_valid = 0; redirect_target = 0;
      trap_valid = 0; trap_vector = 0; call_push = 0; ret_pop = 0;
      model_reset();

      //  st rd tgt           tr vec       ps pp  exp_pc        mis emp full
      add(0, 0, 0,            0, 0,        0, 0, 32'h04,        0, 1, 0);
      add(0, 0, 0,            0, 0,        0, 0, 32'h08,        0, 1, 0);
      add(0, 1, 32'hA0,       0, 0,        0, 0, 32'hA0,        0, 1, 0);
      add(0, 0, 0,            0, 0,        0, 0, 32'hA4,        0, 1, 0);
      add(1, 0, 0,            0, 0,        0, 0, 32'hA4,        0, 1, 0);
      add(1, 0, 0,            0, 0,        0, 0, 32'hA4,        0, 1, 0);
      add(1, 0, 0,            0, 0,        0, 0, 32'hA4,        0, 1, 0);
      add(1, 1, 32'h200,      0, 0,        0, 0, 32'h200,       0, 1, 0);
      add(0, 1, 32'h10,       0, 0,        0, 0, 32'h10,        0, 1, 0);
      add(0, 1, 32'hA2,       0, 0,        0, 0, 32'h10,        1, 1, 0);
      add(0, 0, 0,            0, 0,        0, 0, 32'h14,        0, 1, 0);
      add(0, 1, 32'h40,       0, 0,        0, 0, 32'h40,        0, 1, 0);
      add(0, 0, 0,            0, 0,        1, 0, 32'h44,        0, 0, 0);
      add(0, 1, 32'h100,      0, 0,        0, 0, 32'h100,       0, 0, 0);
      add(0, 0, 0,            0, 0,        0, 1, 32'h44,        0, 1, 0);
      add(0, 0, 0,            0, 0,        0, 1, 32'h48,        0, 1, 0);
      add(0, 0, 0,            0, 0,        1, 0, 32'h4C,        0, 0, 0);
      add(0, 0, 0,            0, 0,        1, 0, 32'h50,        0, 0, 0);
      add(0, 0, 0,            0, 0,        1, 0, 32'h54,        0, 0, 0);
      add(0, 0, 0,            0, 0,        1, 0, 32'h58,        0, 0, 1);
      add(0, 0, 0,            0, 0,        1, 0, 32'h5C,        0, 0, 1);
      add(0, 0, 0,            0, 0,        0, 1, 32'h5C,        0, 0, 0);
      add(0, 0, 0,            0, 0,        0, 1, 32'h58,        0, 0, 0);
      add(0, 0, 0,            0, 0,        0, 1, 32'h54,        0, 0, 0);
      add(0, 0, 0,            0, 0,        0, 1, 32'h50,        0, 1, 0);
      add(0, 0, 0,            0, 0,        0, 1, 32'h54,        0, 1, 0);
      add(0, 0, 0,            0, 0,        1, 0, 32'h58,        0, 0, 0);
      add(0, 0, 0,            0, 0,        1, 0, 32'h5C,        0, 0, 0);
      add(1, 1, 32'h300,      1, 32'h803,  0, 0, 32'h800,       0, 1, 0);
      add(0, 0, 0,            0, 0,        1, 0, 32'h804,       0, 0, 0);
      add(0, 1, 32'h900,      0, 0,        0, 0, 32'h900,       0, 0, 0);
      add(0, 0, 0,            0, 0,        1, 1, 32'h804,       0, 0, 0);
      add(0, 0, 0,            0, 0,        0, 1, 32'h904,       0, 1, 0);
      add(0, 0, 0,            0, 0,        1, 1, 32'h908,       0, 0, 0);
      add(0, 0, 0,            0, 0,        0, 1, 32'h908,       0, 1, 0);
      add(1, 0, 0,            0, 0,        1, 1, 32'h908,       0, 1, 0);
      add(0, 1, 32'hC00,      0, 0,        1, 0, 32'hC00,       0, 1, 0);
      add(0, 1, 32'hFFFF_FFFC,0, 0,        0, 0, 32'hFFFF_FFFC, 0, 1, 0);
      add(0, 0, 0,            0, 0,        0, 0, 32'h0,         0, 1, 0);

      #12;
      chk("reset_pc", pc, RV);
      chk("reset_mis", {31'd0, misaligned}, 32'd0);
      chk("reset_empty", {31'd0, ras_empty}, 32'd1);
      chk("reset_full", {31'd0, ras_full}, 32'd0);
      chk("reset_pc_plus4", pc_plus4, RV + 32'd4);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         step(vecs[i].st, vecs[i].rd, vecs[i].tg, vecs[i].tr, vecs[i].tv, vecs[i].ps, vecs[i].pp);
         chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
         chk($sformatf("vec%0d_mis", i), {31'd0, misaligned}, {31'd0, vecs[i].exp_mis});
         chk($sformatf("vec%0d_empty", i), {31'd0, ras_empty}, {31'd0, vecs[i].exp_empty});
         chk($sformatf("vec%0d_full", i), {31'd0, ras_full}, {31'd0, vecs[i].exp_full});
      end

      for (int n = 0; n < 2000; n++) begin
         logic [31:0] tg;
         tg = $urandom();
         if ($urandom_range(0, 3) != 0) tg[1:0] = 2'b00;
         step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, tg,
              $urandom_range(0, 31) == 0, $urandom(),
              $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      end

      // Asynchronous reset asserted between edges must act immediately.
      step(0, 1, 32'h500, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_rst_pc", pc, RV);
      chk("async_rst_empty", {31'd0, ras_empty}, 32'd1);
      chk("async_rst_mis", {31'd0, misaligned}, 32'd0);
      #3;
      rst_n = 1'b1;
      step(0, 0, 0, 0, 0, 0, 1);
      chk("post_rst_pc", pc, RV + 32'd4);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("post_rst_pc2", pc, RV + 32'd8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the fetch stage. It replaces the single-mux PC register with a priority-resolved next-PC selector. Sources are trap vector, ALU branch/jump redirect, return-address-stack prediction, and sequential increment, with stall support and target-misalignment detection. It sits between the ALU/control path (redirect, trap) and the instruction memory address port (`pc`).

## Interface
- `XLEN`, 32, PC and target width in bits
- `RESET_VECTOR`, 32'h0000_0000, PC value loaded on reset
- `RAS_DEPTH`, 4, return-address-stack entries; power of two, ≥2

- `clk`  in  1  system clock, rising-edge active
- `rst_n`  in  1  reset; asynchronous, active-low
- `stall`  in  1  hold PC and RAS (pipeline back-pressure)
- `redirect_valid`  in  1  taken branch/jump from ALU
- `redirect_target`  in  XLEN  redirect destination
- `trap_valid`  in  1  exception/interrupt entry
- `trap_vector`  in  XLEN  trap handler address; bits [1:0] ignored, treated as 0
- `call_push`  in  1  fetched instruction is a call; push `pc_plus4`
- `ret_pop`  in  1  fetched instruction is a return; predict from RAS
- `pc`  out  XLEN  current fetch address (registered)
- `pc_plus4`  out  XLEN  `pc + 4`, combinational, modulo 2^XLEN
- `misaligned`  out  1  registered one-cycle pulse; last redirect target had bits [1:0] ≠ 0
- `ras_empty`  out  1  RAS holds no entries
- `ras_full`  out  1  RAS holds `RAS_DEPTH` entries

## Operation
- Reset (async assert): `pc`=`RESET_VECTOR`, `misaligned`=0, RAS count=0, `ras_empty`=1, `ras_full`=0. Release takes effect at the next rising edge.
- Next-PC priority per edge, highest first:
  1. `trap_valid`: `pc` ← {`trap_vector`[XLEN-1:2], 2'b00}; RAS flushed (count=0); overrides stall.
  2. `redirect_valid`, target aligned: `pc` ← `redirect_target`; overrides stall; `call_push`/`ret_pop` ignored this cycle.
  3. `redirect_valid`, target[1:0] ≠ 0: `pc` holds; `misaligned` ← 1 for one cycle; RAS untouched.
  4. `stall`: `pc` and RAS hold; push/pop ignored.
  5. `ret_pop` with RAS non-empty: `pc` ← top entry; count−1.
  6. Otherwise: `pc` ← `pc_plus4` (wraps 0xFFFF_FFFC → 0x0000_0000 at XLEN=32).
- `misaligned` is 0 on every edge not in case 3.
- RAS is a circular buffer with a top pointer and a saturating count 0..`RAS_DEPTH`.
  - `call_push` alone (cases 5/6 eligible): write `pc_plus4` at top+1; count+1, saturating. When full, the oldest entry is overwritten silently and count stays `RAS_DEPTH`.
  - `call_push` and `ret_pop`, non-empty: `pc` ← top entry, then top is replaced with the current `pc_plus4`; count unchanged.
  - `call_push` and `ret_pop`, empty: `pc` ← `pc_plus4`; push `pc_plus4`; count=1.
  - `ret_pop` on empty: falls to sequential; count stays 0 (no underflow).
- `ras_empty` = (count==0) and `ras_full` = (count==`RAS_DEPTH`), both derived from registered count.

## Timing
- All state updates on the rising `clk` edge; one-cycle latency from any input to `pc`.
- `pc_plus4`, `ras_empty`, `ras_full` settle combinationally from registered state in the same cycle.
- Inputs are sampled at the edge; the control path holds them stable across the edge.
- Reset mid-operation: async clear regardless of stall/trap/redirect; RAS contents need not be cleared, count only.
- No handshake: redirect and trap are single-cycle strobes and are never queued.

## Test plan
- Reset then free-run with all controls low: `pc` = 0x00, 0x04, 0x08 on consecutive edges; `ras_empty`=1.
- `redirect_valid`=1, target 0xA0 for one cycle: next `pc`=0xA0, then 0xA4. With `stall`=1 held 3 cycles, `pc` stays 0xA4. Redirect 0x200 during stall: `pc`=0x200 on the next edge.
- Redirect to 0xA2 from `pc`=0x10: `pc` stays 0x10, `misaligned`=1 for exactly one cycle, then `pc`=0x14.
- RAS: `call_push` at `pc`=0x40, redirect to 0x100, then `ret_pop`: `pc`=0x44, `ras_empty`=1. Push 5 times with `RAS_DEPTH`=4: `ras_full`=1. Then 4 pops return the last four pushed addresses in LIFO order, and a fifth pop gives sequential `pc`.
- Simultaneous `trap_valid` (vector 0x803) and `redirect_valid` (0x300) with `stall`=1 and 2 RAS entries: `pc`=0x800, `ras_empty`=1.
- `XLEN`=32, redirect to 0xFFFF_FFFC, free-run: `pc`=0x0000_0000 next. Assert `rst_n`=0 mid-cycle: `pc`=`RESET_VECTOR` immediately, before the next edge.
